mdu_seq: RTL and testbench
==========================

# mdu_seq

Parametrised sequential multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU. It generalises the fixed MDU with configurable operand width and independent multiply/divide latencies, and defines results for divide-by-zero and signed overflow. An optional flush port lets the pipeline abort an in-flight operation. The core drives `start`/`op` from `MDUEN`/`MDUCtrl` and uses `busy` as `MDUBusy` for stall generation.

## Interface
- `WIDTH`, 32: operand and HI/LO width (≥ 2).
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (≥ 1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥ 1).
- `clk` in 1: the only clock, rising-edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: operation request, sampled at the rising edge.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `a` in WIDTH: rs operand; also the MTHI/MTLO data.
- `b` in WIDTH: rt operand.
- `flush` in 1: abort request; the port exists only with `MDU_FLUSH_EN`.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse in the cycle after HI/LO are committed.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **Reset** (`reset`=0 at an edge): `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0, state IDLE. Reset has priority over every other input, including in mid-operation, and the partial result is discarded.
- **State machine**: IDLE → RUN on an accepted MULT/MULTU/DIV/DIVU. RUN → IDLE when the counter reaches its limit, and HI/LO are committed on that edge.
- **Acceptance**: `start`=1 in IDLE is accepted. On acceptance the block latches `a`, `b`, `op` and loads the counter with `MULT_CYCLES` or `DIV_CYCLES`.
- **Ignored requests**:
  - `start`=1 in RUN is ignored for every op. The core's stall logic never issues this, but the behaviour is defined.
  - Ops 11x are ignored.
- **MTHI/MTLO**: accepted only in IDLE. The write happens at the accepting edge, single-cycle, with no `busy` and no `done`.
- **Arithmetic** (on latched operands):
  - MULT: signed 2·WIDTH product; HI = upper half, LO = lower half.
  - MULTU: unsigned 2·WIDTH product; HI = upper half, LO = lower half.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient in LO, remainder in HI.
- **Boundary results**:
  - Divide by zero (either signedness): LO = all ones, HI = `a`.
  - Signed DIV of MIN by −1: LO = MIN, HI = 0.
- **Internal algorithm**: free (combinational product with a delay counter, or radix-2 iteration), as long as the visible latency is exact.
- **HI/LO stability**: HI/LO keep their old values throughout RUN. Only a commit or MTHI/MTLO changes them.

## Timing
- Request accepted at edge T0. `busy`=1 during cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- At edge T0+N: HI/LO are updated, `busy`→0, `done`→1 for exactly one cycle.
- A new `start` is accepted at edge T0+N, i.e. back-to-back.
  - For a MULT/DIV started at that edge, `busy` stays 1 with no gap.
  - For an MTHI/MTLO at that edge, the MT write overrides the commit for the targeted register only.
- MTHI at edge T0 makes `hi` = `a` visible in cycle T0+1.

## Configuration
- **`MDU_FLUSH_EN` defined**:
  - `flush`=1 at an edge in RUN aborts the operation. The block returns to IDLE with `busy`=0, `done`=0 and HI/LO unchanged.
  - `flush` at the completion edge wins over the commit.
  - `flush` in IDLE also blocks acceptance of `start` at the same edge.
- **`MDU_FLUSH_EN` undefined**: no `flush` port, and operations always run to completion.

## Test plan
- Reset, then MULT `a`=0xFFFFFFFE, `b`=3 → `busy` high exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA and one `done` pulse.
- DIVU 7/2 followed by DIV −7/2 (0xFFFFFFF9/2) back-to-back:
  - first result: `lo`=3, `hi`=1;
  - second result: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF;
  - `busy` is continuous for 20 cycles.
- Boundary divides:
  - DIV 0x12345678/0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A → `hi`/`lo` take these values one cycle after each request, with `busy` never asserted. An MTHI issued while `busy`=1 leaves `hi` unchanged.
- Reset (`reset`=0) in the 3rd busy cycle of a MULT → `busy`=0, `hi`=`lo`=0, and no `done`.
- With `MDU_FLUSH_EN`: `flush` in the 4th cycle of a DIV with prior `hi`=1, `lo`=2 → `busy` drops next cycle, `hi`=1 and `lo`=2 retained, no `done`.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with HI/LO registers for the E stage.
// The result is computed combinationally from latched operands. A down-counter
// then holds busy for exactly MULT_CYCLES or DIV_CYCLES before HI/LO commit.
// Optional feature macro: MDU_FLUSH_EN adds a flush port that aborts a running op.
module mdu_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic [1:0]         r_op, w_op_nxt;   // bit1: divide, bit0: unsigned
  logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt;
  logic               w_busy_nxt, w_done_nxt;
  logic               w_flush, w_last, w_accept;

`ifdef MDU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Arithmetic on latched operands
  logic               w_signed, w_neg_a, w_neg_b, w_b_zero;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod, w_result;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_div_b, w_uq, w_ur, w_q, w_r;

  assign w_signed = ~r_op[0];
  // Sign/zero extension to 2*WIDTH makes one multiplier serve both signednesses
  assign w_mul_a  = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
  assign w_mul_b  = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod   = w_mul_a * w_mul_b;

  assign w_neg_a  = w_signed & r_a[WIDTH-1];
  assign w_neg_b  = w_signed & r_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -r_a : r_a;
  assign w_mag_b  = w_neg_b ? -r_b : r_b;
  assign w_b_zero = (r_b == '0);
  // Divisor forced to 1 on zero so the divider never sees x; the result is overridden below
  assign w_div_b  = w_b_zero ? WIDTH'(1) : w_mag_b;
  assign w_uq     = w_mag_a / w_div_b;
  assign w_ur     = w_mag_a % w_div_b;
  // MIN / -1 falls out naturally: magnitude 2^(W-1) negates back to MIN, remainder 0
  assign w_q      = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_r      = w_neg_a ? -w_ur : w_ur;

  assign w_result = !r_op[1] ? w_prod :
                    w_b_zero ? {r_a, {WIDTH{1'b1}}} : {w_r, w_q};

  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));
  assign w_accept = start && !w_flush && ((r_state == S_IDLE) || w_last);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter, operand latch and HI/LO update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_hi_nxt    = hi;
    w_lo_nxt    = lo;
    w_done_nxt  = 1'b0;

    if (r_state == S_RUN) begin
      if (w_flush) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else if (w_last) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_hi_nxt    = w_result[2*WIDTH-1:WIDTH];
        w_lo_nxt    = w_result[WIDTH-1:0];
        w_done_nxt  = 1'b1;
      end else begin
        w_cnt_nxt   = r_cnt - CW'(1);
      end
    end

    // A new request can be taken on the completion edge; MT writes override the commit
    if (w_accept) begin
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          w_state_nxt = S_RUN;
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_op_nxt    = op[1:0];
          w_cnt_nxt   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
        OP_MTHI: w_hi_nxt = a;
        OP_MTLO: w_lo_nxt = a;
        default: ;
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_RUN);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      r_a  <= w_a_nxt;
      r_b  <= w_b_nxt;
      r_op <= w_op_nxt;
      hi   <= w_hi_nxt;
      lo   <= w_lo_nxt;
      busy <= w_busy_nxt;
      done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq; expected HI/LO pairs are queued at issue
// and popped by a monitor on every done pulse.
module tb_mdu_seq;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
`ifdef MDU_FLUSH_EN
  logic         flush;
`endif
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;
  int   run = 0, last_run = 0, done_cnt = 0, d0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MDU_FLUSH_EN
    .flush (flush),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected HI/LO per done pulse, tracks busy run length
  always @(negedge clk) begin
    if (prev_done) check("done_pulse_width", 64'(done), 64'd0);
    if (reset === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(mon_e[2*W-1:W]));
        check("lo", 64'(lo), 64'(mon_e[W-1:0]));
      end
    end
    prev_done = done;
    if (busy === 1'b1) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy === 1'b1 && n < 200);
    check("idle_within_bound", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // MULT -2 * 3
    d0 = done_cnt;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("mult_busy_len", 64'(last_run), 64'd5);
    check("mult_done_cnt", 64'(done_cnt - d0), 64'd1);

    // DIVU 7/2 then DIV -7/2 back-to-back
    d0 = done_cnt;
    exp_q.push_back({32'd1, 32'd3});
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(3'b011, 32'd7, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("b2b_busy_len", 64'(last_run), 64'd20);
    check("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);

    // Boundary divides
    exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF});
    issue(3'b010, 32'h1234_5678, 32'd0);
    wait_idle();
    check("div0_busy_len", 64'(last_run), 64'd10);
    exp_q.push_back({32'd0, 32'h8000_0000});
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // MTHI / MTLO single-cycle writes
    d0 = done_cnt;
    issue(3'b100, 32'hA5A5_A5A5, 32'd0);
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthi_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    issue(3'b101, 32'h5A5A_5A5A, 32'd0);
    @(negedge clk);
    check("mtlo_lo", 64'(lo), 64'h5A5A_5A5A);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);
    @(posedge clk); #1;
    check("mt_no_done", 64'(done_cnt - d0), 64'd0);

    // MTHI while busy is ignored; HI holds until commit
    exp_q.push_back({32'd0, 32'd12});
    issue(3'b001, 32'd3, 32'd4);
    issue(3'b100, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    check("mthi_in_run_hi", 64'(hi), 64'hA5A5_A5A5);
    wait_idle();

    // MTLO on the completion edge overrides the LO commit only
    exp_q.push_back({32'd0, 32'h0000_1234});
    issue(3'b001, 32'd5, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    issue(3'b101, 32'h0000_1234, 32'd0);
    wait_idle();
    check("mtlo_ovr_busy_len", 64'(last_run), 64'd5);

    // Op 11x is a no-op
    issue(3'b110, 32'd1, 32'd1);
    @(negedge clk);
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_lo", 64'(lo), 64'h0000_1234);
    @(posedge clk); #1;

    // Reset in the 3rd busy cycle of a MULT
    d0 = done_cnt;
    issue(3'b000, 32'd7, 32'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef MDU_FLUSH_EN
    // Flush in the 4th busy cycle of a DIV
    issue(3'b100, 32'd1, 32'd0);
    issue(3'b101, 32'd2, 32'd0);
    d0 = done_cnt;
    issue(3'b010, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'd1);
    check("flush_lo", 64'(lo), 64'd2);
    repeat (15) @(posedge clk);
    #1;
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);
    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    issue(3'b100, 32'd99, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_hi", 64'(hi), 64'd1);
    @(posedge clk); #1;
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
